xdbl_result_reader: RTL
=======================

# xdbl_result_reader

Streams the xDBL result memories (t2_0, t2_1, t3_0, t3_1) out of the accelerator as a valid/ready word stream. It is the read side of the interface the xDBL controller writes. It sits between the controller's result read ports and the host-facing datapath, and drives the same one-cycle-latency single-port memory read ports the controller exposes. It runs after the controller's `done`, replacing software readback of the results.

## Interface

Parameters:
- `RADIX`, 32: word width in bits.
- `WIDTH_REAL`, 14: words per memory. Must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: one-cycle pulse; begin a readout.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the final word handshake.
- `mem_t2_0_rd_en` / `mem_t2_1_rd_en` / `mem_t3_0_rd_en` / `mem_t3_1_rd_en`, out, 1 each: memory read enables.
- `mem_t2_0_rd_addr` (and the same for t2_1, t3_0, t3_1), out, `CLOG2(WIDTH_REAL)`: word address.
- `mem_t2_0_dout` (and the same for t2_1, t3_0, t3_1), in, `RADIX`: read data, valid one cycle after `rd_en`.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `RADIX`: stream word.
- `out_sel`, out, 2: source memory: 0=t2_0, 1=t2_1, 2=t3_0, 3=t3_1 (3 for the checksum word).
- `out_last`, out, 1: marks the final word of the readout.

## Operation

- **Read order:** t2_0[0..W-1], then t2_1, then t3_0, then t3_1. That is 4·W data words, where W=`WIDTH_REAL`.
- **State machine:**
  - IDLE → READ on `start`.
  - READ issues reads until all 4·W are issued, then goes to DRAIN.
  - DRAIN holds until the buffer empties and no read is in flight, then goes to DONE (or CSUM; see Configuration).
  - DONE pulses `done` for one cycle, then returns to IDLE.
- **Address counter:** one word counter (0..W-1) and one memory select (0..3).
  - The counter drives all four `rd_addr` buses.
  - Only the selected memory's `rd_en` is high, and only in a cycle where a read is issued.
  - When the counter reaches W-1 it wraps to 0 and the select increments.
- **Buffer:** 2-entry FIFO holding {data, sel, last}.
  - A read is issued only if (FIFO count + reads in flight − pop this cycle) < 2. The FIFO therefore never overflows under arbitrary `out_ready`.
  - Data is captured from the selected `dout` in the cycle after its `rd_en`.
- **Handshake:**
  - A word transfers when `out_valid && out_ready`.
  - `out_data`, `out_sel` and `out_last` stay stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- **Restart:** `start` while `busy` is ignored. `start` in the same cycle as `done` is ignored.
- **Reset values:** `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_sel`=0, `out_data`=0, all `rd_en`=0, all `rd_addr`=0. FIFO is empty and the FSM is in IDLE.
- **Reset mid-readout:** everything returns to the reset values immediately. No `done` is produced, and any partial stream is abandoned.

## Timing

- **First word:** with `start` sampled at edge 0:
  - `rd_en` for t2_0[0] is high in cycle 1.
  - Data is captured at edge 2.
  - `out_valid` is high in cycle 2.
- **Throughput:** with `out_ready` held high, one word per cycle. The last data handshake is in cycle 4·W+1, and `done` is high in cycle 4·W+2.
- **Backpressure:** at most 2 words are buffered while `out_ready` is low. Issue resumes the cycle after space frees, with no bubble once steady state is reached.
- **`busy`:** falls in the same cycle `done` is high.

## Configuration

- **`XDBL_READER_CHECKSUM_EN` defined:**
  - After the 4·W data words, a CSUM state emits one extra word. It is the XOR of all 4·W data words, with `out_sel`=3 and `out_last`=1.
  - The last data word then has `out_last`=0.
  - `done` follows the checksum handshake, so the no-stall timing is +1 cycle.
- **Undefined:** no checksum word; `out_last` is set on t3_1[W-1].

## Test plan

- **Back-to-back with no stall:** W=14, memory m holds word i = {m[1:0], i[29:0]}; `start` with `out_ready`=1.
  - 56 words arrive in order with the correct `out_sel`.
  - `out_last` is set on word 56 (checksum build: word 57 = XOR of all 56).
  - `done` is high in cycle 58 (cycle 59 in the checksum build).
- **Random backpressure:** `out_ready` random with 30% duty.
  - Identical word sequence.
  - No drops or duplicates.
  - Data held stable during stalls.
  - `rd_en` never issued when the FIFO plus in-flight reads would exceed 2.
- **Ready low from the start:** `out_ready`=0 for 20 cycles after `start`.
  - Exactly 2 reads are issued.
  - `out_valid` holds t2_0[0].
  - Release gives a seamless stream.
- **`start` while busy:** pulse `start` in cycle 10.
  - Ignored; a single stream of 56 words and one `done`.
  - A new `start` 100 cycles after `done` repeats the identical stream.
- **Reset mid-operation:** assert `rst` low during word 30 for 2 cycles.
  - All outputs return to the reset values asynchronously.
  - No `done`.
  - The following `start` streams from t2_0[0].

Source files
------------

// File: rtl/xdbl_result_reader.sv
// xdbl_result_reader: streams the t2_0, t2_1, t3_0, t3_1 result memories as a valid/ready word stream.
// Define XDBL_READER_CHECKSUM_EN to append an XOR checksum word (out_sel=3, out_last=1) after the data.
module xdbl_result_reader #(
  parameter int RADIX      = 32,
  parameter int WIDTH_REAL = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_t2_0_rd_en,
  output logic                          mem_t2_1_rd_en,
  output logic                          mem_t3_0_rd_en,
  output logic                          mem_t3_1_rd_en,
  output logic [$clog2(WIDTH_REAL)-1:0] mem_t2_0_rd_addr,
  output logic [$clog2(WIDTH_REAL)-1:0] mem_t2_1_rd_addr,
  output logic [$clog2(WIDTH_REAL)-1:0] mem_t3_0_rd_addr,
  output logic [$clog2(WIDTH_REAL)-1:0] mem_t3_1_rd_addr,
  input  logic [RADIX-1:0]              mem_t2_0_dout,
  input  logic [RADIX-1:0]              mem_t2_1_dout,
  input  logic [RADIX-1:0]              mem_t3_0_dout,
  input  logic [RADIX-1:0]              mem_t3_1_dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RADIX-1:0]              out_data,
  output logic [1:0]                    out_sel,
  output logic                          out_last
);
  localparam int AW = $clog2(WIDTH_REAL);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH_REAL - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_CSUM, S_DONE} state_t;
  typedef struct packed {
    logic [RADIX-1:0] data;
    logic [1:0]       sel;
    logic             last;
  } word_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    addr;
  logic [1:0]       sel;
  logic             rd_vld, rd_last;
  logic [1:0]       rd_sel;
  word_t            fifo_q [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_cnt;
  logic [1:0]       pending;
  logic             pop, issue, last_issue, fifo_push, fifo_pop;
  logic [RADIX-1:0] dout_mux;
  word_t            head;
`ifdef XDBL_READER_CHECKSUM_EN
  logic [RADIX-1:0] csum;
`endif

  // A read in flight counts as buffered: its word bypasses the FIFO when the FIFO is empty.
  assign pending    = fifo_cnt + {1'b0, rd_vld};
  assign pop        = out_valid && out_ready;
  assign issue      = (state == S_READ) && ((pending - {1'b0, pop}) < 2'd2);
  assign last_issue = (sel == 2'd3) && (addr == LAST_ADDR);
  assign fifo_pop   = pop && (fifo_cnt != 2'd0);
  assign fifo_push  = rd_vld && !(pop && (fifo_cnt == 2'd0));

  always_comb begin
    case (rd_sel)
      2'd0:    dout_mux = mem_t2_0_dout;
      2'd1:    dout_mux = mem_t2_1_dout;
      2'd2:    dout_mux = mem_t3_0_dout;
      default: dout_mux = mem_t3_1_dout;
    endcase
  end

  assign head = (fifo_cnt != 2'd0) ? fifo_q[rd_ptr] : {dout_mux, rd_sel, rd_last};

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (issue && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if ((pending - {1'b0, pop}) == 2'd0) begin
`ifdef XDBL_READER_CHECKSUM_EN
        state_nxt = S_CSUM;
`else
        state_nxt = S_DONE;
`endif
      end
      S_CSUM:  if (out_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state == S_READ) || (state == S_DRAIN) || (state == S_CSUM);
    done      = (state == S_DONE);
    out_valid = (pending != 2'd0);
    out_data  = '0;
    out_sel   = 2'd0;
    out_last  = 1'b0;
    if (pending != 2'd0) {out_data, out_sel, out_last} = head;
`ifdef XDBL_READER_CHECKSUM_EN
    if (state == S_CSUM) begin
      out_valid = 1'b1;
      out_data  = csum;
      out_sel   = 2'd3;
      out_last  = 1'b1;
    end
`endif
  end

  assign mem_t2_0_rd_en   = issue && (sel == 2'd0);
  assign mem_t2_1_rd_en   = issue && (sel == 2'd1);
  assign mem_t3_0_rd_en   = issue && (sel == 2'd2);
  assign mem_t3_1_rd_en   = issue && (sel == 2'd3);
  assign mem_t2_0_rd_addr = addr;
  assign mem_t2_1_rd_addr = addr;
  assign mem_t3_0_rd_addr = addr;
  assign mem_t3_1_rd_addr = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      sel  <= 2'd0;
    end else if (state == S_IDLE) begin
      addr <= '0;
      sel  <= 2'd0;
    end else if (issue) begin
      if (addr == LAST_ADDR) begin
        addr <= '0;
        sel  <= sel + 2'd1;
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld  <= 1'b0;
      rd_sel  <= 2'd0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_sel  <= sel;
`ifdef XDBL_READER_CHECKSUM_EN
      rd_last <= 1'b0;
`else
      rd_last <= last_issue;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_q[wr_ptr] <= {dout_mux, rd_sel, rd_last};
        wr_ptr         <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
    end
  end

`ifdef XDBL_READER_CHECKSUM_EN
  // Every data word passes through the capture cycle exactly once, so fold it in there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 csum <= '0;
    else if (state == S_IDLE) csum <= '0;
    else if (rd_vld)          csum <= csum ^ dout_mux;
  end
`endif

endmodule
